// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator computer control path: widths, state
// encoding, opcodes and ALU operation codes.
package cpu_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned ALU_W = 3;

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] HALT   = 2'd3;

    typedef enum logic [1:0] {
        StFetch  = FETCH,
        StDecode = DECODE,
        StExec   = EXEC,
        StHalt   = HALT
    } state_e;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_STA = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h4;
    localparam logic [OPC_W-1:0] OP_AND = 4'h5;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h6;
    localparam logic [OPC_W-1:0] OP_NOT = 4'h7;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h8;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h9;
    localparam logic [OPC_W-1:0] OP_LDI = 4'hA;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;
    localparam logic [ALU_W-1:0] ALU_AND  = 3'd3;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'd4;
    localparam logic [ALU_W-1:0] ALU_NOT  = 3'd5;

    typedef struct packed {
        logic             is_mem_alu;
        logic             is_store;
        logic             is_jump;
        logic             is_jz;
        logic             is_halt;
        logic             is_undef;
        logic [ALU_W-1:0] alu_op;
    } dec_t;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bus between the FSM (master) and the datapath (slave).
interface cpu_control_fsm_if;
    import cpu_pkg::*;

    logic             run;
    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             pc_en;
    logic             pc_load;
    logic             ir_en;
    logic             acc_en;
    logic             flag_en;
    logic             addr_sel;
    logic             imm_sel;
    logic             mem_rd;
    logic             mem_wr;
    logic [ALU_W-1:0] alu_op;
    logic             halted;
    logic             illegal;

    modport master (
        input  run, opcode, zero,
        output pc_en, pc_load, ir_en, acc_en, flag_en, addr_sel, imm_sel,
               mem_rd, mem_wr, alu_op, halted, illegal
    );

    modport slave (
        output run, opcode, zero,
        input  pc_en, pc_load, ir_en, acc_en, flag_en, addr_sel, imm_sel,
               mem_rd, mem_wr, alu_op, halted, illegal
    );

endinterface

// File: rtl/cpu_control_fsm_decoder.sv
// Combinational opcode classifier feeding the control FSM.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output dec_t             o_dec
);

    always_comb begin
        o_dec = '0;
        unique case (i_opcode)
            OP_LDA: begin o_dec.is_mem_alu = 1'b1; o_dec.alu_op = ALU_PASS; end
            OP_ADD: begin o_dec.is_mem_alu = 1'b1; o_dec.alu_op = ALU_ADD;  end
            OP_SUB: begin o_dec.is_mem_alu = 1'b1; o_dec.alu_op = ALU_SUB;  end
            OP_AND: begin o_dec.is_mem_alu = 1'b1; o_dec.alu_op = ALU_AND;  end
            OP_OR:  begin o_dec.is_mem_alu = 1'b1; o_dec.alu_op = ALU_OR;   end
            OP_STA: o_dec.is_store = 1'b1;
            OP_NOT: o_dec.alu_op = ALU_NOT;
            OP_LDI: o_dec.alu_op = ALU_PASS;
            OP_JMP: o_dec.is_jump = 1'b1;
            OP_JZ:  o_dec.is_jz = 1'b1;
            OP_HLT: o_dec.is_halt = 1'b1;
            OP_NOP: ;
            default: o_dec.is_undef = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle fetch/decode/execute control unit. Define ILLEGAL_TRAP_EN to make
// undefined opcodes (B-E) set a sticky illegal flag and halt.
module cpu_control_fsm
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    cpu_control_fsm_if.master bus
);

    state_e r_state;
    dec_t   w_dec;
    logic   w_acc_only;

    opcode_decoder u_decoder (
        .i_opcode (bus.opcode),
        .o_dec    (w_dec)
    );

    assign w_acc_only = (bus.opcode == OP_NOT) || (bus.opcode == OP_LDI);

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StFetch;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StFetch: if (bus.run) r_state <= StDecode;
                StDecode: begin
                    if (w_dec.is_halt) begin
                        r_state <= StHalt;
                    end else if (w_dec.is_mem_alu || w_dec.is_store || w_acc_only) begin
                        r_state <= StExec;
                    end else if (w_dec.is_undef) begin
`ifdef ILLEGAL_TRAP_EN
                        r_state   <= StHalt;
                        r_illegal <= 1'b1;
`else
                        r_state <= StFetch;
`endif
                    end else begin
                        r_state <= StFetch;
                    end
                end
                StExec:  r_state <= StFetch;
                StHalt:  r_state <= StHalt;
                default: r_state <= StFetch;
            endcase
        end
    end

    // Outputs are forced low while reset is held so an in-flight STA drops mem_wr at once.
    always_comb begin
        bus.pc_en    = 1'b0;
        bus.pc_load  = 1'b0;
        bus.ir_en    = 1'b0;
        bus.acc_en   = 1'b0;
        bus.flag_en  = 1'b0;
        bus.addr_sel = 1'b0;
        bus.imm_sel  = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.alu_op   = ALU_PASS;
        bus.halted   = 1'b0;
        if (reset) begin
            unique case (r_state)
                StFetch: begin
                    if (bus.run) begin
                        bus.mem_rd = 1'b1;
                        bus.ir_en  = 1'b1;
                        bus.pc_en  = 1'b1;
                    end
                end
                StDecode: begin
                    if (w_dec.is_jump || (w_dec.is_jz && bus.zero)) begin
                        bus.pc_en   = 1'b1;
                        bus.pc_load = 1'b1;
                    end
                end
                StExec: begin
                    if (w_dec.is_mem_alu) begin
                        bus.addr_sel = 1'b1;
                        bus.mem_rd   = 1'b1;
                        bus.acc_en   = 1'b1;
                        bus.flag_en  = 1'b1;
                        bus.alu_op   = w_dec.alu_op;
                    end else if (w_dec.is_store) begin
                        bus.addr_sel = 1'b1;
                        bus.mem_wr   = 1'b1;
                    end else if (w_acc_only) begin
                        bus.acc_en  = 1'b1;
                        bus.flag_en = 1'b1;
                        bus.imm_sel = (bus.opcode == OP_LDI);
                        bus.alu_op  = w_dec.alu_op;
                    end
                end
                StHalt:  bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal = r_illegal;
`else
    assign bus.illegal = 1'b0;
`endif

endmodule
